// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state encoding for the logic-analyser capture core
package la_pkg;

    localparam int LA_STATE_W = 3;

    // Encoding is also decoded by the JTAG register block; keep values fixed.
    typedef enum logic [LA_STATE_W-1:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        READ  = 3'd4
    } la_state_e;

endpackage

// File: rtl/la_trig_match.sv
// rtl/la_trig_match.sv - masked trigger compare, optional rising-match qualifier
// LA_EDGE_TRIG_EN adds the previous-match register and the edge select input.
module la_trig_match
    import la_pkg::*;
#(
    parameter int TRIG_W = 7
) (
`ifdef LA_EDGE_TRIG_EN
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              edge_i,
    input  logic              enter_i,
`endif
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] val_i,
    input  logic [TRIG_W-1:0] mask_i,
    output logic              match_o
);

    logic level;

    assign level = (((trig_i ^ val_i) & mask_i) == '0);

`ifdef LA_EDGE_TRIG_EN
    logic prev_q;
    logic prev_d;

    // Preloading 1 on ARMED entry keeps an already-true condition from firing.
    always_comb begin
        prev_d = level;
        if (enter_i) begin
            prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign match_o = level && (!edge_i || !prev_q);
`else
    assign match_o = level;
`endif

endmodule

// File: rtl/la_capture_core.sv
// rtl/la_capture_core.sv - circular-buffer logic-analyser capture with ordered stream readout
// Optional LA_EDGE_TRIG_EN adds trig_edge_i for rising-match triggering.
module la_capture_core
    import la_pkg::*;
#(
    parameter int DATA_W = 57,
    parameter int TRIG_W = 7,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pre_cnt_i,
    input  logic [TRIG_W-1:0] trig_val_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_i,
`ifdef LA_EDGE_TRIG_EN
    input  logic              trig_edge_i,
`endif
    input  logic [DATA_W-1:0] data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic [2:0]        state_o,
    output logic              triggered_o
);

    la_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] fill_inc;
    logic [ADDR_W-1:0] post_rem_q, post_rem_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic              triggered_q, triggered_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_en;
    logic              rd_en;
    logic              match;

    logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef LA_EDGE_TRIG_EN
    logic enter_armed;

    assign enter_armed = (state_d == ARMED) && (state_q != ARMED);

    la_trig_match #(.TRIG_W(TRIG_W)) u_trig_match (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .edge_i  (trig_edge_i),
        .enter_i (enter_armed),
        .trig_i  (trig_i),
        .val_i   (trig_val_i),
        .mask_i  (trig_mask_i),
        .match_o (match)
    );
`else
    la_trig_match #(.TRIG_W(TRIG_W)) u_trig_match (
        .trig_i  (trig_i),
        .val_i   (trig_val_i),
        .mask_i  (trig_mask_i),
        .match_o (match)
    );
`endif

    assign fill_inc = fill_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        post_rem_d  = post_rem_q;
        trig_ptr_d  = trig_ptr_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        triggered_d = triggered_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arm_i) begin
                    pre_cnt_d   = pre_cnt_i;
                    wr_ptr_d    = '0;
                    fill_d      = '0;
                    triggered_d = 1'b0;
                    state_d     = (pre_cnt_i == '0) ? ARMED : PRE;
                end
            end
            PRE: begin
                wr_en  = 1'b1;
                fill_d = fill_inc;
                if (fill_inc == pre_cnt_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                wr_en = 1'b1;
                if (match) begin
                    trig_ptr_d  = wr_ptr_q;
                    triggered_d = 1'b1;
                    post_rem_d  = ADDR_W'(DEPTH - 1) - pre_cnt_q;
                    state_d     = POST;
                end
            end
            POST: begin
                // A zero remainder must not write: that slot holds the oldest pre-trigger sample.
                if (post_rem_q != '0) begin
                    wr_en      = 1'b1;
                    post_rem_d = post_rem_q - ADDR_W'(1);
                end
                if (post_rem_q <= ADDR_W'(1)) begin
                    state_d     = READ;
                    rd_addr_d   = trig_ptr_q - pre_cnt_q;
                    issue_cnt_d = '0;
                end
            end
            READ: begin
                rd_en = (issue_cnt_q != (ADDR_W+1)'(DEPTH)) && (!rd_valid_q || rd_ready_i);
                if (rd_en) begin
                    rd_addr_d   = rd_addr_q + ADDR_W'(1);
                    issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
                    rd_valid_d  = 1'b1;
                    rd_last_d   = (issue_cnt_q == (ADDR_W+1)'(DEPTH - 1));
                end else if (rd_valid_q && rd_ready_i) begin
                    rd_valid_d = 1'b0;
                end
                if (rd_valid_q && rd_ready_i && rd_last_q) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i) begin
            state_d     = IDLE;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            triggered_d = 1'b0;
            wr_en       = 1'b0;
            rd_en       = 1'b0;
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            post_rem_q  <= '0;
            trig_ptr_q  <= '0;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            post_rem_q  <= post_rem_d;
            trig_ptr_q  <= trig_ptr_d;
            rd_addr_q   <= rd_addr_d;
            issue_cnt_q <= issue_cnt_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Read register only advances on rd_en, so a stalled beat holds its data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr_q];
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_last_o   = rd_last_q;
    assign state_o     = state_q;
    assign triggered_o = triggered_q;

endmodule

// File: tb/tb_la_capture_core.sv
// tb/tb_la_capture_core.sv - directed self-checking bench for la_capture_core (DEPTH=16)
module tb_la_capture_core;

    localparam int DATA_W = 57;
    localparam int TRIG_W = 7;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              arm_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              rd_ready_i = 1'b0;
    logic [ADDR_W-1:0] pre_cnt_i = '0;
    logic [TRIG_W-1:0] trig_val_i = 7'h3F;
    logic [TRIG_W-1:0] trig_mask_i = 7'h7F;
    logic [TRIG_W-1:0] trig_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              rd_last_o;
    logic [2:0]        state_o;
    logic              triggered_o;
`ifdef LA_EDGE_TRIG_EN
    logic              trig_edge_i = 1'b0;
`endif

    logic [DATA_W-1:0] cnt = '0;
    logic [DATA_W-1:0] lo1 = '1, hi1 = '0, lo2 = '1, hi2 = '0;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] beats [32];
    logic              lasts [32];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1'b1;

    assign data_i = cnt;
    assign trig_i = ((cnt >= lo1 && cnt <= hi1) || (cnt >= lo2 && cnt <= hi2)) ? 7'h3F : 7'h00;

    la_capture_core #(
        .DATA_W(DATA_W), .TRIG_W(TRIG_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .pre_cnt_i   (pre_cnt_i),
        .trig_val_i  (trig_val_i),
        .trig_mask_i (trig_mask_i),
        .trig_i      (trig_i),
`ifdef LA_EDGE_TRIG_EN
        .trig_edge_i (trig_edge_i),
`endif
        .data_i      (data_i),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_data_o   (rd_data_o),
        .rd_last_o   (rd_last_o),
        .state_o     (state_o),
        .triggered_o (triggered_o)
    );

    task automatic clear_ranges();
        lo1 = '1; hi1 = '0; lo2 = '1; hi2 = '0;
    endtask

    task automatic arm(input logic [ADDR_W-1:0] pre, output logic [DATA_W-1:0] a);
        @(negedge clk);
        a = cnt;
        pre_cnt_i = pre;
        arm_i = 1'b1;
        @(negedge clk);
        arm_i = 1'b0;
    endtask

    task automatic read_capture(input bit stall, input logic [DATA_W-1:0] base, output int n);
        int stalls;
        int cyc;
        bit done;
        n = 0; stalls = 0; cyc = 0; done = 0;
        for (int i = 0; i < 32; i++) begin
            beats[i] = 'x;
            lasts[i] = 1'bx;
        end
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (rd_valid_o) begin
                if (stalls > 0) begin
                    checks++;
                    if (rd_data_o !== base + DATA_W'(n) || rd_last_o !== (n == 15)) begin
                        errors++;
                        $display("FAIL stall_hold beat %0d: data=%0d last=%0b want data=%0d last=%0b",
                                 n, rd_data_o, rd_last_o, base + DATA_W'(n), n == 15);
                    end
                end
                if (stall && (n == 0 || n == 7 || n == 15) && stalls < 3) begin
                    stalls++;
                    rd_ready_i = 1'b0;
                end else begin
                    rd_ready_i = 1'b1;
                    stalls = 0;
                    beats[n] = rd_data_o;
                    lasts[n] = rd_last_o;
                    n++;
                    if (rd_last_o || n >= 32) done = 1;
                end
            end else begin
                rd_ready_i = 1'b1;
            end
        end
        @(negedge clk);
        rd_ready_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout: beats=%0d want last beat within budget", n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({state_o, rd_valid_o, rd_last_o, triggered_o} !== 6'b0 || rd_data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d valid=%0b last=%0b trig=%0b data=%0d want all 0",
                     state_o, rd_valid_o, rd_last_o, triggered_o, rd_data_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (state_o !== S_IDLE || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: state=%0d valid=%0b want 0 0", state_o, rd_valid_o);
        end
    endtask

    task automatic test_mask_zero();
        logic [DATA_W-1:0] a;
        int n;
        clear_ranges();
        trig_mask_i = 7'h00;
        for (int i = 0; i < 200 && cnt != 48; i++) @(negedge clk);
        checks++;
        if (cnt !== 48) begin
            errors++;
            $display("FAIL t2_sync: cnt=%0d want 48", cnt);
        end
        // Arm lands at cnt 49, so the first ARMED sample is 50.
        arm(4'd0, a);
        checks++;
        if (state_o !== S_ARMED) begin
            errors++;
            $display("FAIL t2_skip_pre: state=%0d want %0d", state_o, S_ARMED);
        end
        read_capture(1'b0, 57'd50, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL t2_count: got %0d want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beats[i] !== DATA_W'(50 + i) || lasts[i] !== (i == 15)) begin
                errors++;
                $display("FAIL t2_beat%0d: data=%0d last=%0b want data=%0d last=%0b",
                         i, beats[i], lasts[i], 50 + i, i == 15);
            end
        end
        trig_mask_i = 7'h7F;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] a;
        int n;
        clear_ranges();
        lo1 = 57'd100; hi1 = 57'd100;
        arm(4'd4, a);
        checks++;
        if (a > 57'd90) begin
            errors++;
            $display("FAIL t1_arm_time: armed at %0d want <= 90", a);
        end
        read_capture(1'b0, 57'd96, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL t1_count: got %0d want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beats[i] !== DATA_W'(96 + i) || lasts[i] !== (i == 15)) begin
                errors++;
                $display("FAIL t1_beat%0d: data=%0d last=%0b want data=%0d last=%0b",
                         i, beats[i], lasts[i], 96 + i, i == 15);
            end
        end
        checks++;
        if (triggered_o !== 1'b1 || state_o !== S_IDLE || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL t1_done: trig=%0b state=%0d valid=%0b want 1 0 0", triggered_o, state_o, rd_valid_o);
        end
    endtask

    task automatic test_pre_ignore();
        logic [DATA_W-1:0] a;
        int n;
        clear_ranges();
        arm(4'd8, a);
        lo1 = a + 2; hi1 = a + 3; lo2 = a + 20; hi2 = a + 20;
        repeat (3) @(negedge clk);
        checks++;
        if (state_o !== S_PRE || triggered_o !== 1'b0) begin
            errors++;
            $display("FAIL t3_pre_hold: state=%0d trig=%0b want %0d 0", state_o, triggered_o, S_PRE);
        end
        read_capture(1'b0, a + 12, n);
        checks++;
        if (n !== 16 || beats[8] !== a + 20) begin
            errors++;
            $display("FAIL t3_trigger_beat: count=%0d beat8=%0d want 16 %0d", n, beats[8], a + 20);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beats[i] !== a + DATA_W'(12 + i)) begin
                errors++;
                $display("FAIL t3_beat%0d: data=%0d want %0d", i, beats[i], a + DATA_W'(12 + i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] a;
        int n;
        clear_ranges();
        arm(4'd15, a);
        lo1 = a + 25; hi1 = a + 25;
        read_capture(1'b1, a + 10, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL t4_count: got %0d want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beats[i] !== a + DATA_W'(10 + i) || lasts[i] !== (i == 15)) begin
                errors++;
                $display("FAIL t4_beat%0d: data=%0d last=%0b want data=%0d last=%0b",
                         i, beats[i], lasts[i], a + DATA_W'(10 + i), i == 15);
            end
        end
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] a;
        int n;
        int i;
        clear_ranges();
        arm(4'd4, a);
        lo1 = a + 10; hi1 = a + 10;
        for (i = 0; i < 60 && state_o !== S_POST; i++) @(negedge clk);
        checks++;
        if (state_o !== S_POST) begin
            errors++;
            $display("FAIL t5_reach_post: state=%0d want %0d", state_o, S_POST);
        end
        repeat (2) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks++;
        if (state_o !== S_IDLE || rd_valid_o !== 1'b0 || triggered_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_abort: state=%0d valid=%0b trig=%0b want 0 0 0", state_o, rd_valid_o, triggered_o);
        end
        clear_ranges();
        arm(4'd4, a);
        lo1 = a + 10; hi1 = a + 10;
        read_capture(1'b0, a + 6, n);
        checks++;
        if (n !== 16 || beats[4] !== a + 10 || lasts[15] !== 1'b1) begin
            errors++;
            $display("FAIL t5_rearm: count=%0d beat4=%0d last15=%0b want 16 %0d 1", n, beats[4], lasts[15], a + 10);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (beats[k] !== a + DATA_W'(6 + k)) begin
                errors++;
                $display("FAIL t5_beat%0d: data=%0d want %0d", k, beats[k], a + DATA_W'(6 + k));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DATA_W-1:0] a;
        int i;
        clear_ranges();
        arm(4'd4, a);
        lo1 = a + 10; hi1 = a + 10;
        for (i = 0; i < 80 && rd_valid_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL t5_reach_read: valid=%0b want 1", rd_valid_o);
        end
        rd_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({state_o, rd_valid_o, rd_last_o, triggered_o} !== 6'b0 || rd_data_o !== '0) begin
            errors++;
            $display("FAIL t5_async_reset: state=%0d valid=%0b last=%0b trig=%0b data=%0d want all 0",
                     state_o, rd_valid_o, rd_last_o, triggered_o, rd_data_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        rd_ready_i = 1'b0;
        checks++;
        if (state_o !== S_IDLE || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_no_resume: state=%0d valid=%0b want 0 0", state_o, rd_valid_o);
        end
    endtask

`ifdef LA_EDGE_TRIG_EN
    task automatic test_edge_trigger();
        logic [DATA_W-1:0] a;
        int n;
        clear_ranges();
        trig_edge_i = 1'b1;
        lo1 = '0; hi1 = cnt + 10;
        arm(4'd0, a);
        hi1 = a + 5; lo2 = a + 10; hi2 = a + 10;
        read_capture(1'b0, a + 10, n);
        checks++;
        if (n !== 16 || beats[0] !== a + 10 || beats[15] !== a + 25) begin
            errors++;
            $display("FAIL t6_edge: count=%0d beat0=%0d beat15=%0d want 16 %0d %0d",
                     n, beats[0], beats[15], a + 10, a + 25);
        end
        trig_edge_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_mask_zero();
        test_basic();
        test_pre_ignore();
        test_backpressure();
        test_abort();
        test_reset_mid_read();
`ifdef LA_EDGE_TRIG_EN
        test_edge_trigger();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
